// File: rtl/register_pkg.sv
// register_pkg: shared defaults and update-priority encoding for the register block
package register_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_RESET_VAL = 0;
  typedef enum logic [1:0] {LOAD, INC, DEC, HOLD} ctrl_e;
endpackage

// File: rtl/register_bus_driver.sv
// bus_driver: WIDTH-wide tri-state buffer, drives d onto bus while en is high
module bus_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  inout  wire  [WIDTH-1:0] bus
);
  assign bus = en ? d : 'z;
endmodule

// File: rtl/register.sv
// register: bus-loadable register with tri-state readback; REGISTER_INCDEC_EN enables inc/dec
module register
  import register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  inout  wire  [WIDTH-1:0] bus,
  input  logic             clk,
  input  logic             clr,
  input  logic             wa,
  input  logic             oa,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zf,
  output logic             nf
);
  ctrl_e ctrl;
`ifdef REGISTER_INCDEC_EN
  assign ctrl = wa ? LOAD : inc ? INC : dec ? DEC : HOLD;
`else
  logic unused_incdec;
  assign unused_incdec = inc ^ dec;
  assign ctrl = wa ? LOAD : HOLD;
`endif
  assign zf = q == '0;
  assign nf = q[WIDTH-1];
  // state update; a load while we drive the bus keeps q rather than sampling our own drive
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) q <= RESET_VAL;
    else
      case (ctrl)
        LOAD:    q <= oa ? q : bus;
        INC:     q <= q + WIDTH'(1);
        DEC:     q <= q - WIDTH'(1);
        default: q <= q;
      endcase
  end
  bus_driver #(.WIDTH(WIDTH)) u_drv (.en(oa), .d(q), .bus(bus));
endmodule

// File: tb/tb_register.sv
// tb_register: table-driven check of register load/hold/inc/dec plus reset corner cases
module tb_register;
`ifdef REGISTER_INCDEC_EN
  localparam bit INCDEC = 1'b1;
`else
  localparam bit INCDEC = 1'b0;
`endif
  typedef struct {
    logic wa, oa, inc, dec, ext;
    logic [7:0] val, exp;
  } vec_t;
  logic clk = 1'b0, clr = 1'b0, wa = 1'b0, oa = 1'b0, inc = 1'b0, dec = 1'b0;
  logic tb_en = 1'b0;
  logic [7:0] tb_val = 8'h00;
  wire [7:0] bus;
  logic [7:0] q;
  logic zf, nf;
  int vecs = 0, errs = 0;
  vec_t tbl[14];
  assign bus = tb_en ? tb_val : 'z;
  register dut (.bus(bus), .clk(clk), .clr(clr), .wa(wa), .oa(oa), .inc(inc), .dec(dec), .q(q), .zf(zf), .nf(nf));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_q(input string name, input logic [7:0] exp);
    chk({name, ".q"}, q, exp);
    chk({name, ".zf"}, {7'd0, zf}, {7'd0, exp == 8'h00});
    chk({name, ".nf"}, {7'd0, nf}, {7'd0, exp[7]});
  endtask
  task automatic drive(input logic w, o, i, d, e, input logic [7:0] v);
    @(negedge clk);
    wa = w; oa = o; inc = i; dec = d; tb_en = e; tb_val = v;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 1, 8'h29, 8'h29};
    tbl[1]  = '{0, 1, 0, 0, 0, 8'h00, 8'h29};
    tbl[2]  = '{0, 0, 0, 0, 1, 8'h10, 8'h29};
    tbl[3]  = '{1, 1, 0, 0, 0, 8'h00, 8'h29};
    tbl[4]  = '{1, 0, 0, 0, 1, 8'hFF, 8'hFF};
    tbl[5]  = '{0, 1, 1, 0, 0, 8'h00, INCDEC ? 8'h00 : 8'hFF};
    tbl[6]  = '{0, 1, 0, 1, 0, 8'h00, 8'hFF};
    tbl[7]  = '{1, 0, 0, 0, 1, 8'h05, 8'h05};
    tbl[8]  = '{0, 1, 1, 1, 0, 8'h00, INCDEC ? 8'h06 : 8'h05};
    tbl[9]  = '{0, 0, 0, 1, 0, 8'h00, 8'h05};
    tbl[10] = '{1, 0, 1, 1, 1, 8'h80, 8'h80};
    tbl[11] = '{0, 1, 0, 0, 0, 8'h00, 8'h80};
    tbl[12] = '{1, 0, 0, 1, 1, 8'h00, 8'h00};
    tbl[13] = '{0, 1, 0, 1, 0, 8'h00, INCDEC ? 8'hFF : 8'h00};
    // reset held across an edge: controls ignored, readback still works
    drive(1, 1, 1, 0, 0, 8'h00);
    chk_q("rst_hold", 8'h00);
    chk("rst_bus", bus, 8'h00);
    drive(0, 1, 0, 0, 0, 8'h00);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk_q("rst_release", 8'h00);
    chk("rst_release_bus", bus, 8'h00);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].wa, tbl[i].oa, tbl[i].inc, tbl[i].dec, tbl[i].ext, tbl[i].val);
      chk_q($sformatf("vec%0d", i), tbl[i].exp);
      if (tbl[i].oa && !tbl[i].ext) chk($sformatf("vec%0d.bus", i), bus, tbl[i].exp);
    end
    // inc held for three edges
    drive(1, 0, 0, 0, 1, 8'h05);
    drive(0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 1, 0, 0, 8'h00);
    chk_q("inc3", INCDEC ? 8'h08 : 8'h05);
    // asynchronous clear between edges
    drive(1, 0, 0, 0, 1, 8'h80);
    chk_q("pre_clr", 8'h80);
    @(negedge clk);
    wa = 1'b0; tb_en = 1'b0;
    #1 clr = 1'b0;
    #1 chk_q("async_clr", 8'h00);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
    chk_q("post_clr", 8'h00);
    drive(1, 0, 0, 0, 1, 8'h3C);
    chk_q("first_load", 8'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter WIDTH, default 8: data and bus width in bits.
REQ-002 Parameter RESET_VAL, default 0: value loaded on reset.
REQ-003 Port bus  inout  WIDTH: shared tri-state data bus; sampled on load, driven when output-enabled.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge. One clock only.
REQ-005 Port clr  input  1: reset, asynchronous, active-low; clears the register to RESET_VAL.
REQ-006 Port wa  input  1: write (load) enable, active-high.
REQ-007 Port oa  input  1: output enable, active-high.
REQ-008 Port inc  input  1: increment request, active-high (see Configuration).
REQ-009 Port dec  input  1: decrement request, active-high (see Configuration).
REQ-010 Port q  output  WIDTH: current register contents, always driven.
REQ-011 Port zf  output  1: high when q == 0.
REQ-012 Port nf  output  1: equals q[WIDTH-1].

Function
REQ-013 Rising clk with wa=1: register loads bus value; q updates after the edge; 1-cycle latency.
REQ-014 oa=1: bus driven with q (combinational, same cycle); oa=0: bus fully high-Z.
REQ-015 wa=1 and oa=1 together: register reloads its own value, so q is unchanged; no X is created.
REQ-016 Update priority per edge: wa > inc > dec > hold.
REQ-017 inc: q <= q+1 modulo 2^WIDTH (0xFF -> 0x00); dec: q <= q-1 modulo 2^WIDTH (0x00 -> 0xFF).
REQ-018 inc=1 and dec=1 with wa=0: increment wins.
REQ-019 No control asserted: q holds indefinitely.
REQ-020 zf and nf are combinational from q; they are not registered.
REQ-021 wa=1 with bus undriven (high-Z) loads X/Z as-is; the block does not sanitise it.

Reset
REQ-022 clr=0: q = RESET_VAL immediately, independent of clk; zf/nf follow q.
REQ-023 While clr=0, wa/inc/dec are ignored; oa still controls bus drive (drives RESET_VAL when oa=1).
REQ-024 Deassertion of clr takes effect at the next rising clk; the first load occurs on the first edge after release.

Configuration
REQ-025 Macro REGISTER_INCDEC_EN: when defined, inc/dec behave per REQ-016 to REQ-018.
REQ-026 Without REGISTER_INCDEC_EN, the inc and dec ports still exist but are ignored; only load and hold remain.

Structure
REQ-027 Package register_pkg holds the default WIDTH and RESET_VAL constants and a control-priority enum (LOAD, INC, DEC, HOLD).
REQ-028 One sub-module, bus_driver (WIDTH-wide tri-state buffer with enable), implements the bus drive; the state register stays in register.

Verification
REQ-029 clr=0, then release; oa=1 -> bus=0x00, zf=1, nf=0.
REQ-030 External driver puts 0x29 on bus, wa=1, oa=0, one edge; then wa=0, oa=1, external driver released -> bus=0x29, q=0x29.
REQ-031 q=0x29; external 0x10 presented with wa=0 -> q stays 0x29; wa=1, oa=1 for one edge -> q stays 0x29.
REQ-032 With REGISTER_INCDEC_EN: load 0xFF, inc one edge -> q=0x00, zf=1; dec one edge -> q=0xFF, nf=1.
REQ-033 Load 0x80, then pulse clr low between clock edges -> q=0x00 immediately, before the next edge.
REQ-034 Without REGISTER_INCDEC_EN: q=0x05, inc=1 for 3 edges -> q stays 0x05.
